// File: rtl/cardinal_noc_pkg.sv
// Shared NoC definitions: NIC register map, packet field positions, traffic-gen FSM states.
package cardinal_noc_pkg;

    localparam logic [1:0] NIC_IN_BUF  = 2'b00;
    localparam logic [1:0] NIC_IN_STS  = 2'b01;
    localparam logic [1:0] NIC_OUT_BUF = 2'b10;
    localparam logic [1:0] NIC_OUT_STS = 2'b11;

    localparam int unsigned NIC_STS_BIT = 63;
    localparam int unsigned PKT_SRC_PAD = 16;
    localparam int unsigned PKT_SRC_ID  = 30;
    localparam int unsigned PKT_PLD_ID  = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_IN,
        S_CHK_IN,
        S_RD_IN,
        S_CAP,
        S_POLL_OUT,
        S_CHK_OUT,
        S_WR_OUT,
        S_EVAL,
        S_DONE
    } gen_state_t;

    // Packets are numbered [0:63], bit 0 being the MSB (vc bit).
    function automatic logic [0:63] build_pkt(input logic [1:0] node_id,
                                              input logic [1:0] dir,
                                              input logic [0:29] seq);
        build_pkt = {seq[15], dir, 5'b0, 8'b0, 14'b0, node_id, node_id, seq};
    endfunction

    function automatic logic pkt_bad(input logic [0:63] pkt, input logic [1:0] node_id);
        pkt_bad = (pkt[PKT_SRC_ID +: 2] == node_id) ||
                  (pkt[PKT_SRC_PAD +: 14] != '0) ||
                  (pkt[PKT_PLD_ID +: 2] != pkt[PKT_SRC_ID +: 2]);
    endfunction

endpackage

// File: rtl/cardinal_sat_cnt16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module cardinal_sat_cnt16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/cardinal_nic_traffic_gen.sv
// Processor-side NoC traffic source/sink: injects NUM_PKTS packets, drains and checks arrivals.
module cardinal_nic_traffic_gen
    import cardinal_noc_pkg::*;
#(
    parameter logic [1:0]  NODE_ID  = 2'd0,
    parameter int unsigned NUM_PKTS = 16,
    parameter logic [1:0]  DIR      = 2'b01,
    parameter int unsigned GAP      = 0,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] rx_expect,
    output logic [1:0]  addr_nic,
    output logic [0:63] din_nic,
    input  logic [0:63] dout_nic,
    output logic        nicEn,
    output logic        nicWrEn,
    output logic [15:0] sent_cnt,
    output logic [15:0] rcvd_cnt,
    output logic [15:0] err_cnt,
    output logic        done,
    output logic        timeout
);

    localparam logic [15:0] NUM_PKTS16 = 16'(NUM_PKTS);
    localparam logic [7:0]  GAP8       = 8'(GAP);
    localparam logic [31:0] TIMEOUT32  = 32'(TIMEOUT);

    gen_state_t  state;
    logic [0:29] seq;
    logic [7:0]  gap_cnt;
    logic [31:0] to_cnt;
    logic        start_ok;
    logic        unused_dout;

    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
    assign unused_dout = ^{dout_nic[0:15], dout_nic[34:62]};

    cardinal_sat_cnt16 u_sent (.clk(clk), .reset(reset), .clear(start_ok),
                               .enable(state == S_WR_OUT), .count(sent_cnt));
    cardinal_sat_cnt16 u_rcvd (.clk(clk), .reset(reset), .clear(start_ok),
                               .enable(state == S_CAP), .count(rcvd_cnt));
    cardinal_sat_cnt16 u_err  (.clk(clk), .reset(reset), .clear(start_ok),
                               .enable((state == S_CAP) && pkt_bad(dout_nic, NODE_ID)),
                               .count(err_cnt));

    // NIC strobes are registered: they are loaded on entry to the state that owns the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr_nic <= '0;
            din_nic  <= '0;
            nicEn    <= 1'b0;
            nicWrEn  <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            seq      <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            nicEn    <= 1'b0;
            nicWrEn  <= 1'b0;
            addr_nic <= '0;
            din_nic  <= '0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 8'd1;
            if ((state == S_CAP) || (state == S_WR_OUT)) begin
                to_cnt <= '0;
            end else if ((state != S_IDLE) && (state != S_DONE) && (to_cnt != TIMEOUT32)) begin
                to_cnt <= to_cnt + 32'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        seq      <= '0;
                        gap_cnt  <= '0;
                        to_cnt   <= '0;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        state    <= S_POLL_IN;
                        nicEn    <= 1'b1;
                        addr_nic <= NIC_IN_STS;
                    end
                end
                S_POLL_IN: state <= S_CHK_IN;
                S_CHK_IN: begin
                    if (dout_nic[NIC_STS_BIT]) begin
                        state    <= S_RD_IN;
                        nicEn    <= 1'b1;
                        addr_nic <= NIC_IN_BUF;
                    end else if ((sent_cnt < NUM_PKTS16) && (gap_cnt == '0)) begin
                        state    <= S_POLL_OUT;
                        nicEn    <= 1'b1;
                        addr_nic <= NIC_OUT_STS;
                    end else begin
                        state <= S_EVAL;
                    end
                end
                S_RD_IN:    state <= S_CAP;
                S_CAP:      state <= S_EVAL;
                S_POLL_OUT: state <= S_CHK_OUT;
                S_CHK_OUT: begin
                    if (!dout_nic[NIC_STS_BIT]) begin
                        state    <= S_WR_OUT;
                        nicEn    <= 1'b1;
                        nicWrEn  <= 1'b1;
                        addr_nic <= NIC_OUT_BUF;
                        din_nic  <= build_pkt(NODE_ID, DIR, seq);
                    end else begin
                        state <= S_EVAL;
                    end
                end
                S_WR_OUT: begin
                    seq     <= seq + 30'd1;
                    gap_cnt <= GAP8;
                    state   <= S_EVAL;
                end
                S_EVAL: begin
                    if ((sent_cnt == NUM_PKTS16) && (rcvd_cnt >= rx_expect)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (to_cnt == TIMEOUT32) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        state    <= S_POLL_IN;
                        nicEn    <= 1'b1;
                        addr_nic <= NIC_IN_STS;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
